// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo write-port arbiter: state encoding and the
// round-robin pointer wrap helper.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_st_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority encoder: picks the first set request at or
// after ptr, wrapping from NUM_REQ-1 back to 0.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    localparam logic [ID_W:0] NumW = (ID_W + 1)'(NUM_REQ);

    logic [ID_W:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // ptr and i are both below NUM_REQ, so one subtraction wraps correctly
            pos = {1'b0, ptr} + (ID_W + 1)'(i);
            if (pos >= NumW) begin
                pos = pos - NumW;
            end
            if (!any && req[pos[ID_W-1:0]]) begin
                any = 1'b1;
                idx = pos[ID_W-1:0];
            end
        end
        if (any) begin
            gnt = NUM_REQ'(1) << idx;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers,
// with atomic bursts and a forced release when a locked owner goes quiet.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din,
    input  logic                      fifo_full,
    output logic                      busy,
    output logic [ID_W-1:0]           active_id,
    output logic                      timeout_err
);

    localparam int unsigned    CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    arb_st_e            st_q, st_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    logic               accept_last;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Never grant into a full fifo or during reset; a locked owner excludes everyone else
    always_comb begin
        gnt = '0;
        if (!rst && !fifo_full) begin
            if (st_q == ST_LOCKED) begin
                gnt[owner_q] = req_valid[owner_q];
            end else if (pick_any) begin
                gnt = pick_gnt;
            end
        end
    end

    always_comb begin
        fifo_din = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                fifo_din = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready   = gnt;
    assign accept      = |(req_valid & gnt);
    assign accept_last = |(req_last & gnt);
    assign fifo_wr_en  = accept;

    always_comb begin
        st_d          = st_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = pick_idx;
                    if (accept_last) begin
                        rr_ptr_d = ID_W'(wrap_inc(32'(pick_idx), NUM_REQ));
                    end else begin
                        st_d       = ST_LOCKED;
                        idle_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    idle_cnt_d = '0;
                    if (accept_last) begin
                        st_d     = ST_IDLE;
                        rr_ptr_d = ID_W'(wrap_inc(32'(owner_q), NUM_REQ));
                    end
                end else if (!req_valid[owner_q] && !fifo_full) begin
                    // Fifo stalls do not count as owner silence
                    if (TIMEOUT != 0 && idle_cnt_q == CntLast) begin
                        st_d          = ST_IDLE;
                        rr_ptr_d      = ID_W'(wrap_inc(32'(owner_q), NUM_REQ));
                        idle_cnt_d    = '0;
                        timeout_err_d = 1'b1;
                    end else if (idle_cnt_q != '1) begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q          <= ST_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            st_q          <= st_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = (st_q == ST_LOCKED);
    assign active_id   = owner_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run against a
// cycle-level reference model, with a 32-deep queue standing in for the fifo.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int TOUT  = 8;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        fifo_full;
    logic        busy;
    logic [1:0]  active_id;
    logic        timeout_err;
    logic        rd_en;

    int checks;
    int errors;

    logic [7:0] fifo_mem[$];
    int         fifo_cnt;

    fifo_wr_arbiter #(
        .NUM_REQ (NREQ),
        .DATA_W  (8),
        .TIMEOUT (TOUT),
        .ID_W    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .fifo_full   (fifo_full),
        .busy        (busy),
        .active_id   (active_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    assign fifo_full = (fifo_cnt >= DEPTH);

    always @(posedge clk) begin
        if (rd_en === 1'b1 && fifo_mem.size() > 0) void'(fifo_mem.pop_front());
        if (fifo_wr_en === 1'b1) fifo_mem.push_back(fifo_din);
        fifo_cnt <= fifo_mem.size();
    end

    // Reference model: arbitration described as "who may write this cycle"
    int m_locked, m_owner, m_ptr, m_idle, m_terr;

    function automatic int m_grant(logic [3:0] v, logic full, logic r);
        if (r || full) return -1;
        if (m_locked != 0) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic m_step(input logic [3:0] v, input logic [3:0] l, input logic full,
                          input logic r);
        int g;
        g = m_grant(v, full, r);
        m_terr = 0;
        if (r) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
        end else if (m_locked != 0) begin
            if (g >= 0) begin
                m_idle = 0;
                if (l[g]) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % NREQ;
                end
            end else if (!full && !v[m_owner]) begin
                m_idle++;
                if (m_idle == TOUT) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % NREQ;
                    m_terr   = 1;
                    m_idle   = 0;
                end
            end
        end else if (g >= 0) begin
            m_owner = g;
            if (l[g]) m_ptr = (g + 1) % NREQ;
            else begin
                m_locked = 1;
                m_idle   = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_and_reset();
        req_valid = '0; req_last = '0; req_data = '0;
        rd_en = 1'b1;
        for (int i = 0; i < 40 && fifo_cnt > 0; i++) tick();
        rd_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0;
        req_valid = 4'hF; req_last = 4'hF; req_data = 32'h13121110;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (fifo_wr_en !== 1'b0) begin
                errors++; $display("FAIL reset_wr_en: got %0b want 0", fifo_wr_en);
            end
            checks++;
            if (req_ready !== 4'b0) begin
                errors++; $display("FAIL reset_ready: got %b want 0000", req_ready);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++;
        if (active_id !== 2'd0) begin
            errors++; $display("FAIL reset_active_id: got %0d want 0", active_id);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_timeout_err: got %0b want 0", timeout_err);
        end
        checks++;
        if (fifo_cnt !== 0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        req_valid = 4'hF; req_last = 4'hF; req_data = 32'h13121110;
        for (int k = 0; k < 8; k++) begin
            e = 4'b0001 << (k % 4);
            @(negedge clk);
            checks++;
            if (req_ready !== e) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, e);
            end
            checks++;
            if (fifo_wr_en !== 1'b1 || fifo_din !== 8'(8'h10 + k % 4)) begin
                errors++;
                $display("FAIL rr_data[%0d]: got en=%0b din=%0h want en=1 din=%0h",
                         k, fifo_wr_en, fifo_din, 8'h10 + k % 4);
            end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (fifo_cnt !== 8) begin errors++; $display("FAIL rr_count: got %0d want 8", fifo_cnt); end
        checks++;
        if (active_id !== 2'd3) begin
            errors++; $display("FAIL rr_active_id: got %0d want 3", active_id);
        end
        tick();
    endtask

    task automatic test_burst();
        logic [7:0] exp_q[6];
        flush_and_reset();
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'b0011;
            req_last  = {3'b001, (k == 4)};
            req_data  = {16'h0, 8'hB0, 8'(8'hA0 + k)};
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0001 || fifo_din !== 8'(8'hA0 + k)) begin
                errors++;
                $display("FAIL burst_beat[%0d]: got ready=%b din=%0h want ready=0001 din=%0h",
                         k, req_ready, fifo_din, 8'hA0 + k);
            end
            checks++;
            if (busy !== (k >= 1)) begin
                errors++; $display("FAIL burst_busy[%0d]: got %0b want %0b", k, busy, k >= 1);
            end
            tick();
        end
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010 || fifo_din !== 8'hB0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_handover: got ready=%b din=%0h busy=%0b want 0010 b0 0",
                     req_ready, fifo_din, busy);
        end
        tick();
        req_valid = '0;
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB0};
        checks++;
        if (fifo_mem.size() != 6) begin
            errors++; $display("FAIL burst_fifo_size: got %0d want 6", fifo_mem.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (fifo_mem[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL burst_fifo[%0d]: got %0h want %0h", i, fifo_mem[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (active_id !== 2'd1) begin
            errors++; $display("FAIL burst_active_id: got %0d want 1", active_id);
        end
    endtask

    task automatic test_full();
        flush_and_reset();
        req_valid = 4'b0010; req_last = 4'b0010;
        for (int i = 0; i < DEPTH; i++) begin
            req_data = $urandom;
            tick();
        end
        @(negedge clk);
        checks++;
        if (fifo_cnt !== DEPTH) begin
            errors++; $display("FAIL full_count: got %0d want %0d", fifo_cnt, DEPTH);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL full_stall[%0d]: got en=%0b ready=%b want 0 0000",
                         i, fifo_wr_en, req_ready);
            end
            tick();
        end
        rd_en = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_wr_en !== 1'b0) begin
            errors++; $display("FAIL full_pop_cycle: got en=%0b want 0", fifo_wr_en);
        end
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0010 || fifo_cnt !== DEPTH - 1) begin
            errors++;
            $display("FAIL full_refill: got en=%0b ready=%b cnt=%0d want 1 0010 31",
                     fifo_wr_en, req_ready, fifo_cnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if (fifo_wr_en !== 1'b0 || fifo_cnt !== DEPTH) begin
            errors++;
            $display("FAIL full_again: got en=%0b cnt=%0d want 0 32", fifo_wr_en, fifo_cnt);
        end
        tick();
    endtask

    task automatic test_timeout();
        flush_and_reset();
        for (int k = 0; k < 2; k++) begin
            req_valid = 4'b0100; req_last = 4'b0000;
            req_data  = {8'hD0, 8'(8'hC0 + k), 16'h0};
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0100) begin
                errors++; $display("FAIL to_beat[%0d]: got %b want 0100", k, req_ready);
            end
            tick();
        end
        req_valid = 4'b1000; req_last = 4'b1000;
        for (int k = 0; k < TOUT; k++) begin
            @(negedge clk);
            checks++;
            if (fifo_wr_en !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0 ||
                active_id !== 2'd2) begin
                errors++;
                $display("FAIL to_wait[%0d]: got en=%0b busy=%0b terr=%0b id=%0d want 0 1 0 2",
                         k, fifo_wr_en, busy, timeout_err, active_id);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: got terr=%0b busy=%0b want 1 0", timeout_err, busy);
        end
        checks++;
        if (req_ready !== 4'b1000 || fifo_din !== 8'hD0) begin
            errors++;
            $display("FAIL to_next: got ready=%b din=%0h want 1000 d0", req_ready, fifo_din);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || active_id !== 2'd3 || fifo_cnt !== 3) begin
            errors++;
            $display("FAIL to_after: got terr=%0b id=%0d cnt=%0d want 0 3 3",
                     timeout_err, active_id, fifo_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        flush_and_reset();
        req_valid = 4'b0100; req_last = 4'b0000; req_data = 32'h00550000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0100) begin
                errors++; $display("FAIL rmid_beat[%0d]: got %b want 0100", k, req_ready);
            end
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL rmid_rst_cycle: got en=%0b ready=%b want 0 0000", fifo_wr_en, req_ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || active_id !== 2'd0) begin
            errors++; $display("FAIL rmid_state: got busy=%0b id=%0d want 0 0", busy, active_id);
        end
        req_valid = 4'hF; req_last = 4'hF;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rmid_restart: got %b want 0001", req_ready);
        end
        tick();
    endtask

    task automatic test_random();
        int         g;
        logic       full_s;
        logic [3:0] e;
        flush_and_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_terr = 0;
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 149) == 0);
            rd_en     = ($urandom_range(0, 3) == 0);
            req_valid = ((c / 50) % 3 == 2) ? 4'($urandom & $urandom & $urandom) : 4'($urandom);
            req_last  = 4'($urandom & $urandom);
            req_data  = $urandom;
            @(negedge clk);
            full_s = fifo_full;
            g = m_grant(req_valid, full_s, rst);
            e = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            checks++;
            if (req_ready !== e || fifo_wr_en !== (g >= 0)) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got ready=%b en=%0b want ready=%b en=%0b",
                         c, req_ready, fifo_wr_en, e, g >= 0);
            end
            if (g >= 0) begin
                checks++;
                if (fifo_din !== req_data[g*8 +: 8]) begin
                    errors++;
                    $display("FAIL rand_din[%0d]: got %0h want %0h", c, fifo_din, req_data[g*8 +: 8]);
                end
            end
            @(posedge clk);
            m_step(req_valid, req_last, full_s, rst);
            #1;
            checks++;
            if (busy !== (m_locked != 0) || active_id !== 2'(m_owner) ||
                timeout_err !== (m_terr != 0)) begin
                errors++;
                $display("FAIL rand_state[%0d]: got busy=%0b id=%0d terr=%0b want %0d %0d %0d",
                         c, busy, active_id, timeout_err, m_locked, m_owner, m_terr);
            end
        end
        rst = 1'b0; rd_en = 1'b0; req_valid = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_burst();
        test_full();
        test_timeout();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
